// File: rtl/ifns_seq_encoder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ifns_seq_encoder_ctrl_if
// Purpose  : Valid/ready bundle for the sequenced IFNS encoder. It carries
//            the input word channel (source -> encoder) and the codeword
//            channel (encoder -> sink).
// Modports : master - source/sink side (drives in_valid, in_data, out_ready)
//            slave  - encoder side    (drives in_ready, out_valid, out_code)
// Revision : 1.0  initial release
// ============================================================================
interface ifns_seq_encoder_ctrl_if #(
    parameter int DATA_W = 10,
    parameter int CODE_W = 14
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_code
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_code
    );
endinterface
`default_nettype wire

// File: rtl/ifns_seq_encoder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ifns_seq_encoder_ctrl
// Purpose  : Iterative IFNS 10-bit -> 14-digit encoder. One shared
//            compare/subtract stage emits one digit per cycle, d14 first and
//            d1 last, using the Fibonacci thresholds/weights and the
//            carry-previous-digit rule of the combinational IFNS core.
// Ports    : clk        - clock, rising edge
//            rst        - synchronous active-high reset
//            bus        - slave side of the in/out valid/ready bundle
//                         (in_valid, in_ready, in_data,
//                          out_valid, out_ready, out_code[13]=d14..[0]=d1)
//            flush      - synchronous abort of the current encode
//            busy       - state is not IDLE
//            err        - range error (only with IFNS_RANGE_CHK_EN)
// Options  : IFNS_RANGE_CHK_EN - adds err: set when the remainder left for
//            d1 exceeds 1, i.e. the input is not representable.
// Revision : 1.0  initial release
// ============================================================================
module ifns_seq_encoder_ctrl #(
    parameter int DATA_W = 10,
    parameter int CODE_W = 14
) (
    input  wire logic              clk,
    input  wire logic              rst,
    ifns_seq_encoder_ctrl_if.slave bus,
    input  wire logic              flush,
    output logic                   busy
`ifdef IFNS_RANGE_CHK_EN
    ,
    output logic                   err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_LAST_STEP = 4'd13;

    state_t            r_state;
    logic [DATA_W-1:0] r_rem;
    logic [3:0]        r_step;
    logic              r_prev;
    logic [CODE_W-1:0] r_code;
`ifdef IFNS_RANGE_CHK_EN
    logic              r_err;
`endif

    logic [DATA_W-1:0] w_upper;
    logic [DATA_W-1:0] w_weight;
    logic              w_digit;
    logic [DATA_W-1:0] w_rem_next;
    logic [3:0]        w_bit_idx;
    logic              w_accept;

    // Upper threshold U and weight W of the digit produced at each step.
    // Step 0 uses U == W so the generic rule collapses to d = (rem >= 610).
    always_comb begin
        w_upper  = '0;
        w_weight = '0;
        case (r_step)
            4'd0:    begin w_upper = 10'd610; w_weight = 10'd610; end
            4'd1:    begin w_upper = 10'd377; w_weight = 10'd233; end
            4'd2:    begin w_upper = 10'd233; w_weight = 10'd144; end
            4'd3:    begin w_upper = 10'd144; w_weight = 10'd89;  end
            4'd4:    begin w_upper = 10'd89;  w_weight = 10'd55;  end
            4'd5:    begin w_upper = 10'd55;  w_weight = 10'd34;  end
            4'd6:    begin w_upper = 10'd34;  w_weight = 10'd21;  end
            4'd7:    begin w_upper = 10'd21;  w_weight = 10'd13;  end
            4'd8:    begin w_upper = 10'd13;  w_weight = 10'd8;   end
            4'd9:    begin w_upper = 10'd8;   w_weight = 10'd5;   end
            4'd10:   begin w_upper = 10'd5;   w_weight = 10'd3;   end
            4'd11:   begin w_upper = 10'd3;   w_weight = 10'd2;   end
            4'd12:   begin w_upper = 10'd2;   w_weight = 10'd1;   end
            default: begin w_upper = '0;      w_weight = '0;      end
        endcase
    end

    // In the band W <= rem < U either digit value keeps the remainder
    // encodable, so the previous digit is repeated (carry-prev rule).
    always_comb begin
        w_digit = 1'b0;
        if (r_step == c_LAST_STEP) begin
            w_digit = r_rem[0];
        end else if (r_rem >= w_upper) begin
            w_digit = 1'b1;
        end else if (r_rem < w_weight) begin
            w_digit = 1'b0;
        end else begin
            w_digit = r_prev;
        end
    end

    assign w_rem_next = w_digit ? (r_rem - w_weight) : r_rem;
    assign w_bit_idx  = c_LAST_STEP - r_step;
    assign w_accept   = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_step  <= '0;
            r_prev  <= 1'b0;
            r_code  <= '0;
`ifdef IFNS_RANGE_CHK_EN
            r_err   <= 1'b0;
`endif
        end else if (flush && (r_state != S_IDLE)) begin
            // Abort: the word in flight is dropped without output.
            r_state <= S_IDLE;
`ifdef IFNS_RANGE_CHK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rem   <= bus.in_data;
                        r_step  <= '0;
                        r_prev  <= 1'b0;
                        r_code  <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_code[w_bit_idx] <= w_digit;
                    r_rem             <= w_rem_next;
                    r_prev            <= w_digit;
                    r_step            <= r_step + 4'd1;
                    if (r_step == c_LAST_STEP) begin
                        r_state <= S_DONE;
`ifdef IFNS_RANGE_CHK_EN
                        r_err   <= (r_rem[DATA_W-1:1] != '0);
`endif
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
`ifdef IFNS_RANGE_CHK_EN
                        r_err   <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A flush in IDLE suppresses acceptance for that cycle.
    assign bus.in_ready  = (r_state == S_IDLE) && !flush;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_code  = r_code;
    assign busy          = (r_state != S_IDLE);
`ifdef IFNS_RANGE_CHK_EN
    assign err           = r_err;
`endif

endmodule
`default_nettype wire
